// File: rtl/weight_fetch_pkg.sv
// Shared types and constants for the weight fetch engine and its SRAM port.
package weight_fetch_pkg;

  localparam int unsigned DEF_ADDR_W     = 17;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_LEN_W      = 17;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  // Write-request encoding of the weight buffer's sp_ram port (active-low byte enables).
  localparam int unsigned        WREQ_W    = 4;
  localparam logic [WREQ_W-1:0]  WRITE_ENB = 4'h0;
  localparam logic [WREQ_W-1:0]  WRITE_DIS = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } wf_state_t;

endpackage

// File: rtl/wf_sync_fifo.sv
// Synchronous FIFO with combinational read of the head entry and occupancy count.
module wf_sync_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/weight_fetch_unit.sv
// Claims the weight SRAM, streams a contiguous run of words out over valid/ready,
// then releases the SRAM with a finish handshake.
module weight_fetch_unit
  import weight_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned LEN_W      = DEF_LEN_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [LEN_W-1:0]    num_words_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                buf_start_o,
  output logic                buf_finish_o,
  output logic                mem_cs,
  output logic                mem_oe,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WREQ_W-1:0]   mem_W_req,
  output logic [DATA_W-1:0]   mem_W_data,
  input  logic [DATA_W-1:0]   mem_R_data,
  output logic                wgt_valid_o,
  output logic [DATA_W-1:0]   wgt_data_o,
  output logic                wgt_last_o,
  input  logic                wgt_ready_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);

  wf_state_t          state;
  logic [ADDR_W-1:0]  base;
  logic [LEN_W-1:0]   count;
  logic [LEN_W-1:0]   issued;
  logic               inflight;
  logic               inflight_last;

  logic [CNT_W-1:0]   occ;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W:0]    fifo_dout;

  logic [CNT_W:0]     credit_used;
  logic               issue;
  logic               issue_last;
  logic               pop;
  logic               last_accept;

  // Reads already in flight hold a FIFO slot, so occupancy never exceeds the depth.
  always_comb begin
    credit_used = {1'b0, occ} + {{CNT_W{1'b0}}, inflight};
    issue       = (state == ST_FETCH) && (issued < count) && !fifo_full &&
                  (credit_used < DEPTH_V);
    issue_last  = issue && (issued == count - LEN_W'(1));
  end

  assign pop         = wgt_valid_o & wgt_ready_i;
  assign last_accept = pop & wgt_last_o;

  assign wgt_valid_o = ~fifo_empty;
  assign wgt_data_o  = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
  assign wgt_last_o  = ~fifo_empty & fifo_dout[DATA_W];

  assign mem_cs     = issue;
  assign mem_oe     = issue;
  assign mem_addr   = issue ? (base + ADDR_W'(issued)) : '0;
  assign mem_W_req  = WRITE_DIS;
  assign mem_W_data = '0;

  wf_sync_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .din   ({inflight_last, mem_R_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      base          <= '0;
      count         <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      buf_start_o   <= 1'b0;
      buf_finish_o  <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue_last;
      done_o        <= 1'b0;
      buf_finish_o  <= 1'b0;
      if (issue) issued <= issued + LEN_W'(1);

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            base        <= base_addr_i;
            count       <= num_words_i;
            issued      <= '0;
            state       <= ST_ARM;
            busy_o      <= 1'b1;
            buf_start_o <= 1'b1;
          end
        end
        ST_ARM: begin
          if (count == '0) begin
            state        <= ST_DONE;
            done_o       <= 1'b1;
            buf_finish_o <= 1'b1;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (last_accept) begin
            state        <= ST_DONE;
            done_o       <= 1'b1;
            buf_finish_o <= 1'b1;
          end else if (issue_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_accept) begin
            state        <= ST_DONE;
            done_o       <= 1'b1;
            buf_finish_o <= 1'b1;
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          busy_o      <= 1'b0;
          buf_start_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Self-checking bench: cycle-level credit/stream reference model against the fetch engine.
module tb_weight_fetch_unit;
  import weight_fetch_pkg::*;

  localparam int unsigned AW    = 17;
  localparam int unsigned DW    = 32;
  localparam int unsigned LW    = 17;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] num_words_i;
  logic          busy_o, done_o, buf_start_o, buf_finish_o;
  logic          mem_cs, mem_oe;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_W_req;
  logic [DW-1:0] mem_W_data;
  logic [DW-1:0] mem_R_data;
  logic          wgt_valid_o, wgt_last_o, wgt_ready_i;
  logic [DW-1:0] wgt_data_o;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sram [0:(1<<AW)-1];

  always #5 clk = ~clk;

  weight_fetch_unit #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i), .busy_o(busy_o), .done_o(done_o),
    .buf_start_o(buf_start_o), .buf_finish_o(buf_finish_o),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_addr(mem_addr), .mem_W_req(mem_W_req),
    .mem_W_data(mem_W_data), .mem_R_data(mem_R_data),
    .wgt_valid_o(wgt_valid_o), .wgt_data_o(wgt_data_o), .wgt_last_o(wgt_last_o),
    .wgt_ready_i(wgt_ready_i)
  );

  // One-cycle read latency SRAM
  always @(posedge clk) begin
    if (mem_cs && mem_oe) mem_R_data <= sram[mem_addr];
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  // rmode: 0 ready always high, 1 pattern 1,0,0, 2 random.
  task automatic run_job(input logic [AW-1:0] b, input int unsigned n, input int unsigned rmode,
                         input int unsigned restart_c, input int unsigned abort_k);
    int unsigned c, issued, popped, visible, done_c, dut_done_c;
    int unsigned iq[$];
    bit exp_cs, exp_valid, r, prev_hold;
    logic [DW-1:0] prev_data;
    logic prev_last;
    logic [AW-1:0] a;

    @(negedge clk);
    start_i = 1'b1; base_addr_i = b; num_words_i = LW'(n); wgt_ready_i = 1'b0;
    c = 0; issued = 0; popped = 0; visible = 0; prev_hold = 0; dut_done_c = 0;
    done_c = (n == 0) ? 2 : 0;
    check_val("idle_busy", 64'(busy_o), 0);

    for (;;) begin
      @(negedge clk);
      c++;
      start_i = (restart_c != 0 && c == restart_c);
      if (start_i) begin
        base_addr_i = b ^ 17'h0555;
        num_words_i = LW'(n + 3);
      end

      if (abort_k != 0 && popped == abort_k) begin
        start_i = 1'b0;
        rst = 1'b1;
        #1;
        check_val("rst_busy",   64'(busy_o), 0);
        check_val("rst_done",   64'(done_o), 0);
        check_val("rst_bstart", 64'(buf_start_o), 0);
        check_val("rst_bfin",   64'(buf_finish_o), 0);
        check_val("rst_valid",  64'(wgt_valid_o), 0);
        check_val("rst_last",   64'(wgt_last_o), 0);
        check_val("rst_cs",     64'(mem_cs), 0);
        check_val("rst_addr",   64'(mem_addr), 0);
        check_val("rst_data",   64'(wgt_data_o), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check_val("post_rst_busy",  64'(busy_o), 0);
          check_val("post_rst_done",  64'(done_o), 0);
          check_val("post_rst_cs",    64'(mem_cs), 0);
          check_val("post_rst_valid", 64'(wgt_valid_o), 0);
        end
        return;
      end

      case (rmode)
        0:       r = 1'b1;
        1:       r = ((c % 3) == 1);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      wgt_ready_i = r;

      while (iq.size() > 0 && iq[0] + 2 <= c) begin
        void'(iq.pop_front());
        visible++;
      end
      exp_cs    = (n > 0) && (c >= 2) && (issued < n) && ((issued - popped) < DEPTH);
      exp_valid = (visible > popped);

      check_val("cs",      64'(mem_cs), 64'(exp_cs));
      check_val("oe",      64'(mem_oe), 64'(exp_cs));
      if (exp_cs) check_val("addr", 64'(mem_addr), 64'(AW'(b + AW'(issued))));
      check_val("valid",   64'(wgt_valid_o), 64'(exp_valid));
      check_val("busy",    64'(busy_o), 64'(c >= 1 && (done_c == 0 || c <= done_c)));
      check_val("bstart",  64'(buf_start_o), 64'(c >= 1 && (done_c == 0 || c <= done_c)));
      check_val("done",    64'(done_o), 64'(c == done_c));
      check_val("bfinish", 64'(buf_finish_o), 64'(c == done_c));
      check_val("wreq",    64'(mem_W_req), 64'(4'hF));
      check_val("wdata",   64'(mem_W_data), 0);
      if (exp_valid) begin
        a = AW'(b + AW'(popped));
        check_val("data", 64'(wgt_data_o), 64'(word_at(a)));
        check_val("last", 64'(wgt_last_o), 64'(popped == n - 1));
      end
      if (prev_hold) begin
        check_val("hold_data", 64'(wgt_data_o), 64'(prev_data));
        check_val("hold_last", 64'(wgt_last_o), 64'(prev_last));
      end
      if (done_o && dut_done_c == 0) dut_done_c = c;

      if (exp_cs) begin
        issued++;
        iq.push_back(c);
      end
      prev_hold = exp_valid && !r;
      prev_data = wgt_data_o;
      prev_last = wgt_last_o;
      if (exp_valid && r) begin
        popped++;
        if (popped == n) done_c = c + 1;
      end

      if (done_c != 0 && c == done_c) break;
      if (c > 4000) begin
        check_val("timeout", 1, 0);
        break;
      end
    end

    if (rmode == 0) check_val("done_cycle", 64'(dut_done_c), 64'((n == 0) ? 2 : n + 4));
    check_val("words", 64'(popped), 64'(n));
    @(negedge clk);
    start_i = 1'b0;
    wgt_ready_i = 1'b0;
    check_val("end_busy", 64'(busy_o), 0);
    check_val("end_done", 64'(done_o), 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram[i] = 32'hA000_0000 + 32'(i);
    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; num_words_i = '0; wgt_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_val("r_busy",   64'(busy_o), 0);
    check_val("r_done",   64'(done_o), 0);
    check_val("r_bstart", 64'(buf_start_o), 0);
    check_val("r_bfin",   64'(buf_finish_o), 0);
    check_val("r_valid",  64'(wgt_valid_o), 0);
    check_val("r_last",   64'(wgt_last_o), 0);
    check_val("r_cs",     64'(mem_cs), 0);
    check_val("r_oe",     64'(mem_oe), 0);
    check_val("r_addr",   64'(mem_addr), 0);
    check_val("r_data",   64'(wgt_data_o), 0);
    check_val("r_wdata",  64'(mem_W_data), 0);
    rst = 1'b0;

    run_job(17'h00010, 8, 0, 0, 0);
    run_job(17'h00010, 8, 1, 0, 0);
    run_job(17'h00010, 0, 0, 0, 0);
    run_job(17'h1FFFE, 4, 0, 0, 0);
    run_job(17'h00100, 6, 0, 5, 0);
    run_job(17'h00200, 8, 0, 0, 3);
    run_job(17'h00300, 2, 0, 0, 0);
    run_job(17'h1FFFD, 1, 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      run_job(AW'($urandom), $urandom_range(0, 20), 2, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_fetch_unit.md
# weight_fetch_unit

Requester-side engine for the weight buffer's `sp_ram_intf` port. On a start pulse it claims the weight SRAM, streams a contiguous run of 32-bit weight words from a base word address, and returns the run to the convolution datapath over a valid/ready stream. It then releases the SRAM with a `finish` handshake so the buffer can return to AXI access. It sits in the EPU between the controller and the weight-buffer memory port.

## Interface
Parameters:
- `ADDR_W`, 17: SRAM word-address width (byte address bits [18:2]).
- `DATA_W`, 32: weight word width.
- `LEN_W`, 17: width of the word-count field.
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of two and ≥2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start_i` in 1: one-cycle request pulse; sampled only in IDLE.
- `base_addr_i` in ADDR_W: first word address; captured with `start_i`.
- `num_words_i` in LEN_W: word count; captured with `start_i`.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `done_o` out 1: one-cycle pulse when the run completes.
- `buf_start_o` out 1: SRAM ownership request to the weight buffer (its `start_i`).
- `buf_finish_o` out 1: release pulse to the weight buffer (its `finish_i`).
- `mem` `sp_ram_intf` master side: drives `cs`, `oe`, `addr`, `W_req`, `W_data`; receives `R_data`.
- `wgt_valid_o` out 1: stream word valid.
- `wgt_data_o` out DATA_W: stream word.
- `wgt_last_o` out 1: marks the final word of the run.
- `wgt_ready_i` in 1: consumer accept.

## Operation
- States: IDLE, ARM, FETCH, DRAIN, DONE.
- IDLE → ARM on `start_i`. Latch base and count. Clear the issue and pop counters.
- ARM: lasts 1 cycle. `buf_start_o`=1, no SRAM access. This gives the buffer one cycle to enter its EPU-owned state.
  - Count = 0 goes to DONE.
  - Otherwise goes to FETCH.
- FETCH: a read is issued in a cycle when `issued < count` and `occ + inflight < FIFO_DEPTH`.
  - `inflight` is the 1-bit flag "read issued last cycle".
  - A read drives `cs`=`oe`=1 and `addr = base + issued`, modulo 2^ADDR_W (wraps, no error).
  - After the last issue, go to DRAIN.
- DRAIN: wait until the word tagged last is accepted (`wgt_valid_o & wgt_ready_i & wgt_last_o`), then go to DONE.
  - FETCH jumps straight to DONE if that acceptance occurs there.
- DONE: lasts 1 cycle. `buf_start_o`=1, `buf_finish_o`=1, `done_o`=1. Then IDLE.
  - The buffer exits on `finish & start` in the same cycle.
- `buf_start_o` is high in ARM, FETCH, DRAIN and DONE.
- `W_req` is always WRITE_DIS and `W_data` is always 0; this block never writes.
- The FIFO is written with `R_data` in the cycle after each issue.
  - `wgt_last_o` is set on the entry whose pop index equals count−1.
- A `start_i` while busy is ignored.
- `wgt_ready_i` with the FIFO empty is harmless.
- Reset mid-run:
  - All outputs return to 0 and the FIFO is flushed.
  - State goes to IDLE and no `done_o` is generated.
  - The buffer is reset by the same `rst`.

## Timing
- Reset values: `busy_o`, `done_o`, `buf_start_o`, `buf_finish_o`, `wgt_valid_o`, `wgt_last_o`, `cs`, `oe` are 0. `addr`, `wgt_data_o` and `W_data` are 0.
- SRAM read latency is 1 cycle: `addr` is presented in cycle t and `R_data` is valid in t+1.
- With `start_i` at cycle 0:
  - ARM in cycle 1.
  - First issue in cycle 2.
  - FIFO write at the end of cycle 3.
  - `wgt_valid_o` rises in cycle 4.
- With `wgt_ready_i` held high, throughput is 1 word/cycle.
- For N≥1 words with ready always high, `done_o` is in cycle N+4. That is one cycle after the last-word acceptance, which is in cycle N+3.
- For N=0, `done_o` is in cycle 2.
- Stream rule: while `wgt_valid_o`=1 and `wgt_ready_i`=0, `wgt_data_o`/`wgt_last_o` are held stable.
- Credit rule: a FIFO push and pop in the same cycle are both honoured. Occupancy never exceeds FIFO_DEPTH.

## Structure
- Package `weight_fetch_pkg`: state enum `wf_state_t`, default widths, the WRITE_ENB/WRITE_DIS constants via the existing define header.
- Sub-module `wf_sync_fifo`: synchronous FIFO with parameters DATA_W+1 (last bit) and FIFO_DEPTH. Ports: push, pop, full, empty, count.
- Top block: FSM, issue/pop counters, inflight flag, address adder.

## Test plan
- Base 0x00010, N=8, ready=1, SRAM preloaded with word i = 0xA000_0000+i:
  - Stream 0xA000_0010..0xA000_0017 in cycles 4–11.
  - `wgt_last_o` only on the 8th word.
  - `done_o` in cycle 12 together with `buf_finish_o` and `buf_start_o`.
- Same run with `wgt_ready_i` toggling 1,0,0,1…:
  - Identical data order and no drops.
  - FIFO never overflows; `cs` is held low while credits are exhausted.
  - Data is stable while stalled.
- N=0:
  - `buf_start_o` high in cycles 1–2, `done_o`/`buf_finish_o` in cycle 2.
  - No `cs`, no `wgt_valid_o`.
- Base 0x1FFFE, N=4: addresses issued are 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- `start_i` pulsed again mid-run: ignored, and the original run completes unchanged. Then `rst` asserted after 3 words: all outputs 0 the same cycle, state IDLE, no `done_o`. A fresh start with N=2 succeeds.
